// File: rtl/cnn_pkg.sv
// Shared fixed-point constants and sequencer state type for the CNN layer blocks.
// All bias/activation values are signed Q1.7.
package cnn_pkg;

  localparam int unsigned FRAC      = 7;
  localparam int          Q_MAX     = 127;
  localparam int          Q_MIN     = -128;
  localparam int unsigned ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/conv_bias_act_seq_if.sv
// Streaming and bias-ROM signals of one conv layer's bias/activation stage.
// master = the sequencer, slave = MAC array, next-layer buffer and ROM together.
interface conv_bias_act_seq_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CH_W  = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_acc;
  logic [15:0]             rom_row;
  logic [15:0]             rom_col;
  logic signed [7:0]       rom_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_last;

  modport master (
    input  in_valid, in_acc, rom_data, out_ready,
    output in_ready, rom_row, rom_col, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    output in_valid, in_acc, rom_data, out_ready,
    input  in_ready, rom_row, rom_col, out_valid, out_data, out_ch, out_last
  );

endinterface

// File: rtl/q17_round_sat.sv
// Adds a Q1.7 bias to a Q.14 accumulator, rounds half up to Q1.7, saturates and
// optionally applies ReLU. Purely combinational.
module q17_round_sat
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [7:0]       bias,
  output logic signed [7:0]       result
);

  // Two guard bits keep the bias add and rounding constant from overflowing.
  localparam int unsigned SW = ACC_W + 2;

  localparam logic signed [SW-1:0] RND   = SW'(1) <<< (FRAC - 1);
  localparam logic signed [SW-1:0] MAX_X = SW'(Q_MAX);
  localparam logic signed [SW-1:0] MIN_X = SW'(Q_MIN);

  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] bias_x;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  always_comb begin
    acc_x   = {{2{acc[ACC_W-1]}}, acc};
    bias_x  = {{(SW-8){bias[7]}}, bias};
    sum     = acc_x + (bias_x <<< FRAC) + RND;
    shifted = sum >>> FRAC;
    if (shifted > MAX_X) begin
      result = 8'sd127;
    end else if (shifted < MIN_X) begin
      result = -8'sd128;
    end else begin
      result = shifted[7:0];
    end
    if (RELU_EN && result[7]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/conv_bias_act_seq.sv
// Walks the output channels of one conv layer pass, fetches each channel's bias
// from the external ROM and emits the biased, rounded, saturated activation.
module conv_bias_act_seq
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_CH  = 32,
  parameter int unsigned CH_W    = 5,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         num_pixels,
  output logic                busy,
  output logic                done,
  conv_bias_act_seq_if.master bus
);

  state_e state_q, state_d;

  logic [CH_W-1:0]   ch_q;
  logic [15:0]       pix_q;
  logic [15:0]       npix_q;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic signed [7:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic              out_last_q;

  logic              in_ready;
  logic              fire;
  logic              out_fire;
  logic              ch_wrap;
  logic              last_word;
  logic signed [7:0] act;

  q17_round_sat #(
    .ACC_W  (ACC_W),
    .RELU_EN(RELU_EN)
  ) u_round_sat (
    .acc   (bus.in_acc),
    .bias  (bus.rom_data),
    .result(act)
  );

  always_comb begin
    ch_wrap   = (ch_q == CH_W'(NUM_CH - 1));
    last_word = ch_wrap && (pix_q == npix_q - 16'd1);
    in_ready  = (state_q == StRun) && (!out_valid_q || bus.out_ready);
    fire      = bus.in_valid && in_ready;
    out_fire  = out_valid_q && bus.out_ready;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_pixels == 16'd0) ? StDone : StRun;
      StRun:   if (fire && last_word) state_d = StDrain;
      StDrain: if (out_fire) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      pix_q       <= '0;
      npix_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // busy and done both flip on the edge that leaves StDone.
      done_q  <= (state_q == StDone);
      if (state_q == StDone) begin
        busy_q <= 1'b0;
      end
      if ((state_q == StIdle) && start) begin
        npix_q <= num_pixels;
        ch_q   <= '0;
        pix_q  <= '0;
        busy_q <= 1'b1;
      end
      if (fire) begin
        ch_q        <= ch_wrap ? '0 : ch_q + CH_W'(1);
        pix_q       <= ch_wrap ? pix_q + 16'd1 : pix_q;
        out_valid_q <= 1'b1;
        out_data_q  <= act;
        out_ch_q    <= ch_q;
        out_last_q  <= last_word;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.in_ready  = in_ready;
  assign bus.rom_row   = {{(16 - CH_W){1'b0}}, ch_q};
  assign bus.rom_col   = '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_bias_act_seq.sv
// Directed bench for conv_bias_act_seq with a four-entry bias ROM stub.
// Outputs are sampled 1 time unit after the negedge on which inputs are driven.
module tb_conv_bias_act_seq;

  localparam int NCH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_pixels;
  logic        busy;
  logic        done;

  conv_bias_act_seq_if #(.ACC_W(24), .CH_W(5)) bus ();

  conv_bias_act_seq #(
    .NUM_CH (32),
    .CH_W   (5),
    .ACC_W  (24),
    .RELU_EN(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_pixels(num_pixels),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  logic signed [23:0] nr_acc;
  logic signed [7:0]  nr_bias;
  logic signed [7:0]  nr_res;

  q17_round_sat #(
    .ACC_W  (24),
    .RELU_EN(1'b0)
  ) u_norelu (
    .acc   (nr_acc),
    .bias  (nr_bias),
    .result(nr_res)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.rom_row)
      16'd0:   bus.rom_data = 8'sd31;
      16'd5:   bus.rom_data = 8'sd60;
      16'd8:   bus.rom_data = -8'sd32;
      16'd16:  bus.rom_data = -8'sd55;
      default: bus.rom_data = 8'sd0;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int acc_tab[0:95];
  int rx_data[0:95];

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bias_of(input int ch);
    case (ch)
      0:       return 31;
      5:       return 60;
      8:       return -32;
      16:      return -55;
      default: return 0;
    endcase
  endfunction

  // Reference: floor((acc + bias*128 + 64) / 128), saturate, ReLU.
  function automatic int model(input int acc, input int bias);
    int s;
    int r;
    s = acc + bias * 128 + 64;
    r = (s >= 0) ? s / 128 : -((-s + 127) / 128);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (r < 0) r = 0;
    return r;
  endfunction

  // Runs one pass; abort_at >= 0 stops once that many outputs were taken.
  task automatic run_pass(input int npix, input bit toggle, input int abort_at,
                          input bit poke_start);
    int total;
    int tx;
    int rx;
    int done_cnt;
    int done_cyc;
    int last_fire;
    total     = npix * NCH;
    tx        = 0;
    rx        = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    last_fire = 0;
    for (int c = 0; c < 1000; c++) begin
      start         = (c == 0) || (poke_start && c == 10);
      num_pixels    = (c == 0) ? 16'(npix) : 16'd0;
      bus.out_ready = toggle ? (c % 2 == 1) : 1'b1;
      bus.in_valid  = (tx < total);
      bus.in_acc    = (tx < total) ? 24'(acc_tab[tx]) : 24'd0;
      #1;
      if (abort_at >= 0 && rx == abort_at) break;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        chk("busy_low_at_done", 32'(busy), 0);
      end
      if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", 32'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (rx < total) begin
          rx_data[rx] = int'(bus.out_data);
          chk("out_ch", 32'(bus.out_ch), rx % NCH);
          chk("out_last", 32'(bus.out_last), (rx == total - 1) ? 1 : 0);
          chk("out_data", 32'(bus.out_data), model(acc_tab[rx], bias_of(rx % NCH)));
        end else begin
          chk("extra_output", rx, total - 1);
        end
        rx++;
        last_fire = c;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at < 0) begin
      chk("output_count", rx, total);
      chk("done_pulses", done_cnt, 1);
      chk("done_latency", done_cyc - last_fire, 2);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    num_pixels    = 16'd0;
    bus.in_valid  = 1'b0;
    bus.in_acc    = 24'd0;
    bus.out_ready = 1'b0;
    nr_acc        = 24'sd0;
    nr_bias       = 8'sd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_ch", 32'(bus.out_ch), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_rom_row", 32'(bus.rom_row), 0);
    chk("rst_rom_col", 32'(bus.rom_col), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single pixel, zero accumulators: output is bias alone after ReLU.
    for (int i = 0; i < 96; i++) acc_tab[i] = 0;
    run_pass(1, 1'b0, -1, 1'b0);
    chk("ch0_bias", rx_data[0], 31);
    chk("ch5_bias", rx_data[5], 60);
    chk("ch8_relu", rx_data[8], 0);
    chk("ch16_relu", rx_data[16], 0);

    // Three pixels under 1010 backpressure, with a start poked mid-pass.
    for (int i = 0; i < 96; i++) acc_tab[i] = ((i * 7919) % 60001) - 30000;
    acc_tab[0]  = 16384;
    acc_tab[32] = 64;
    acc_tab[64] = 63;
    run_pass(3, 1'b1, -1, 1'b1);
    chk("sat_high", rx_data[0], 127);
    chk("round_64", rx_data[32], 32);
    chk("round_63", rx_data[64], 31);

    // Empty pass.
    run_pass(0, 1'b0, -1, 1'b0);

    // Abort in pixel 2, then a fresh pass must restart at channel 0.
    run_pass(3, 1'b0, 40, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_out_data", 32'(bus.out_data), 0);
    chk("abort_out_ch", 32'(bus.out_ch), 0);
    chk("abort_out_last", 32'(bus.out_last), 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done), 0);
    end
    @(negedge clk);
    for (int i = 0; i < 96; i++) acc_tab[i] = 0;
    run_pass(1, 1'b0, -1, 1'b0);
    chk("restart_ch0", rx_data[0], 31);

    // ReLU disabled: negative saturation and negative passthrough.
    nr_acc  = -24'sd32768;
    nr_bias = 8'sd31;
    #1;
    chk("sat_low_norelu", 32'(nr_res), -128);
    nr_acc  = 24'sd0;
    nr_bias = -8'sd32;
    #1;
    chk("neg_norelu", 32'(nr_res), -32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_bias_act_seq.md
Name: conv_bias_act_seq

Overview:
Sequencer that walks a conv layer's output channels and drives the read side of that layer's per-channel Q1.7 bias ROM. The ROM has 16-bit row/col addresses and returns signed 8-bit data combinationally.
- For every incoming accumulator word, the block fetches the bias for the current channel, aligns and adds it, rounds and saturates to Q1.7, applies optional ReLU, and emits the result.
- It sits between the conv MAC array and the next layer's input buffer, and owns the channel/pixel counters for one layer pass.

Parameters:
NUM_CH, 32, output channels per pixel (bias ROM rows)
CH_W, 5, channel counter width, $clog2(NUM_CH)
ACC_W, 24, signed accumulator width (Q.14, product of two Q1.7)
FRAC, 7, fractional bits of bias/output
RELU_EN, 1, 1 = clamp negatives to 0 after saturation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a pass; sampled only in IDLE
num_pixels  in  16  pixels in this pass, latched on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of pass
in_valid  in  1  accumulator word valid
in_ready  out  1  block can accept in_acc
in_acc  in  ACC_W  signed accumulator, channel order 0..NUM_CH-1 per pixel
rom_row  out  16  bias ROM row = current channel, zero-extended
rom_col  out  16  bias ROM column, constant 0
rom_data  in  8  signed Q1.7 bias, combinational from rom_row
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  8  signed Q1.7 result
out_ch  out  CH_W  channel index of out_data
out_last  out  1  marks last channel of last pixel

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, ch_cnt=0, pix_cnt=0. Outputs busy, done, out_valid, out_data, out_ch, out_last all 0. rst mid-pass aborts immediately; no done pulse.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch num_pixels. If num_pixels=0 go to DONE, else go to RUN. busy=1 the next cycle.
  - RUN: in_ready = !out_valid | out_ready. Input fire = in_valid & in_ready.
  - On the final fire (ch_cnt=NUM_CH-1 and pix_cnt=num_pixels-1), go to DRAIN.
  - DRAIN: in_ready=0. When out_valid & out_ready, go to DONE.
  - DONE: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
  - start is ignored outside IDLE.
- rom_row = {0, ch_cnt} at all times. rom_col = 0.
- Counters advance on fire. ch_cnt wraps NUM_CH-1 → 0 and increments pix_cnt on wrap.
- Arithmetic, on fire, in width ACC_W+2:
  - s = in_acc + (sign_ext(rom_data) << FRAC) + (1 << (FRAC-1))
  - r = s >>> FRAC (round half up)
  - saturate r to [-128, 127]
  - if RELU_EN, clamp to [0, 127]
- Output register is a single stage; latency is 1 cycle from input fire to out_valid.
  - out_valid sets on fire and clears on out_ready when there is no new fire that cycle.
  - Simultaneous out_ready and fire reloads the register; out_valid stays 1.
  - out_data/out_ch/out_last hold while out_valid & !out_ready.
- With out_ready held high, throughput is 1 word/cycle, no bubbles.

Decomposition:
- Shared package (cnn_pkg):
  - Q1.7 constants: FRAC=7, Q_MAX=127, Q_MIN=-128
  - state typedef {IDLE, RUN, DRAIN, DONE}
  - ACC_W default
- One natural sub-module, q17_round_sat: combinational align/round/saturate/ReLU, reused by later layers.
- The ROM stays external; one instance per layer is selected at integration.

Test Plan:
- Bench uses a ROM stub with ch0=31, ch5=60, ch8=-32, ch16=-55.
- Single pixel, num_pixels=1, in_acc=0 for all channels, out_ready=1:
  - outputs ch0=31, ch5=60, ch8=0 (ReLU), ch16=0
  - out_last only on ch31
  - done pulses once, 2 cycles after the last out fire
- Saturation: ch0 in_acc=16384 (1.0) gives 159 → out_data=127. ch0 in_acc=-32768 with RELU_EN=0 gives -225 → -128.
- Rounding: ch0 in_acc=64 gives (64+3968+64)>>7=32. in_acc=63 gives 31.
- Backpressure: 3 pixels with out_ready toggling 1010…:
  - no lost or duplicated words
  - in_ready=0 whenever out_valid & !out_ready
  - out_ch sequence 0..31 ×3
  - done pulses after 96 outputs
- Edge cases:
  - num_pixels=0 → done pulses 2 cycles after start with no outputs.
  - start asserted while busy → ignored.
  - rst during pixel 2 → all outputs 0 the next cycle; a fresh start then restarts at ch0.
